// File: rtl/pcie_datalink_pkg.sv
// Shared types and defaults for the PCIe data-link layer: DL status, init FSM
// states, default timeouts and a timer-width helper.
package pcie_datalink_pkg;

    typedef enum logic [1:0] {
        DL_DOWN   = 2'd0,
        DL_UP     = 2'd1,
        DL_ACTIVE = 2'd2
    } pcie_dl_status_e;

    typedef enum logic [2:0] {
        ST_INACTIVE = 3'd0,
        ST_FEATURE  = 3'd1,
        ST_INIT     = 3'd2,
        ST_FC1      = 3'd3,
        ST_FC2      = 3'd4,
        ST_ACTIVE   = 3'd5
    } pcie_dl_init_state_e;

    localparam int unsigned DL_FEAT_TIMEOUT = 32'd1024;
    localparam int unsigned DL_FC_TIMEOUT   = 32'd4096;

    // Width able to hold (max limit - 1); never narrower than one bit.
    function automatic int unsigned dl_timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/pcie_dl_timeout_ctr.sv
// Saturating up-counter with synchronous clear; flags when the count equals
// a caller-selected limit.
module pcie_dl_timeout_ctr #(
    parameter int unsigned W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/pcie_dl_init_mvc.sv
// PCIe DLL control/initialisation FSM: optional feature exchange, per-VC
// InitFC1/InitFC2 tracking, FC-init timeout with saturating retry count.
module pcie_dl_init_mvc
    import pcie_datalink_pkg::*;
#(
    parameter int unsigned NUM_VC       = 1,
    parameter bit          FEATURE_EN   = 1'b0,
    parameter int unsigned FEAT_TIMEOUT = DL_FEAT_TIMEOUT,
    parameter int unsigned FC_TIMEOUT   = DL_FC_TIMEOUT,
    parameter int unsigned RETRY_W      = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                phy_link_up_i,
    input  logic [NUM_VC-1:0]   vc_en_i,
    input  logic                init_ack_i,
    input  logic                feat_ack_i,
    input  logic [NUM_VC-1:0]   fc1_stored_i,
    input  logic [NUM_VC-1:0]   fc2_stored_i,
    output logic                soft_reset_o,
    output logic                init_flow_control_o,
    output logic                feat_tx_o,
    output logic [NUM_VC-1:0]   fc1_tx_o,
    output logic [NUM_VC-1:0]   fc2_tx_o,
    output pcie_dl_status_e     link_status_o,
    output logic                timeout_o,
    output logic [RETRY_W-1:0]  retry_cnt_o
);

    localparam int unsigned       TW        = dl_timer_width(FEAT_TIMEOUT, FC_TIMEOUT);
    localparam logic [TW-1:0]     FEAT_LIM  = TW'(FEAT_TIMEOUT - 32'd1);
    localparam logic [TW-1:0]     FC_LIM    = TW'(FC_TIMEOUT - 32'd1);
    localparam logic [NUM_VC-1:0] VC0_MASK  = NUM_VC'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

    pcie_dl_init_state_e state_q, state_d;
    logic [NUM_VC-1:0]   en_q, en_d;
    logic [NUM_VC-1:0]   fc1f_q, fc1f_d;
    logic [NUM_VC-1:0]   fc2f_q, fc2f_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                timeout_q, timeout_d;
    logic                soft_reset_q, soft_reset_d;
    logic                init_fc_q, init_fc_d;
    logic                feat_tx_q, feat_tx_d;
    logic [NUM_VC-1:0]   fc1_tx_q, fc1_tx_d;
    logic [NUM_VC-1:0]   fc2_tx_q, fc2_tx_d;
    pcie_dl_status_e     status_q, status_d;

    logic                timer_clr_s;
    logic                timer_en_s;
    logic [TW-1:0]       timer_lim_s;
    logic                timer_exp_s;
    logic [RETRY_W-1:0]  retry_inc_s;

    assign timer_en_s  = (state_q == ST_FEATURE) || (state_q == ST_FC1) || (state_q == ST_FC2);
    assign timer_lim_s = (state_q == ST_FEATURE) ? FEAT_LIM : FC_LIM;
    assign timer_clr_s = (state_d != state_q);
    assign retry_inc_s = (retry_q == RETRY_MAX) ? retry_q : (retry_q + RETRY_W'(1));

    pcie_dl_timeout_ctr #(.W(TW)) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (timer_clr_s),
        .en_i      (timer_en_s),
        .limit_i   (timer_lim_s),
        .expired_o (timer_exp_s)
    );

    // Next-state, flag, retry and output computation; link loss overrides all.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        fc1f_d    = fc1f_q;
        fc2f_d    = fc2f_q;
        retry_d   = retry_q;
        timeout_d = 1'b0;
        if (!phy_link_up_i) begin
            state_d = ST_INACTIVE;
            fc1f_d  = {NUM_VC{1'b0}};
            fc2f_d  = {NUM_VC{1'b0}};
            retry_d = {RETRY_W{1'b0}};
        end else begin
            case (state_q)
                ST_INACTIVE: state_d = FEATURE_EN ? ST_FEATURE : ST_INIT;
                ST_FEATURE: begin
                    if (feat_ack_i || timer_exp_s) state_d = ST_INIT;
                    else                            state_d = ST_FEATURE;
                end
                ST_INIT: begin
                    if (init_ack_i) begin
                        state_d = ST_FC1;
                        en_d    = vc_en_i | VC0_MASK;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_FC1, ST_FC2: begin
                    if (state_q == ST_FC1) fc1f_d = fc1f_q | (fc1_stored_i & en_q);
                    else                   fc2f_d = fc2f_q | (fc2_stored_i & en_q);
                    // Completion is judged on flags including this cycle's pulses, so it beats expiry.
                    if (&(((state_q == ST_FC1) ? fc1f_d : fc2f_d) | ~en_q)) begin
                        state_d = (state_q == ST_FC1) ? ST_FC2 : ST_ACTIVE;
                    end else if (timer_exp_s) begin
                        state_d   = ST_INIT;
                        timeout_d = 1'b1;
                        retry_d   = retry_inc_s;
                        fc1f_d    = {NUM_VC{1'b0}};
                        fc2f_d    = {NUM_VC{1'b0}};
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACTIVE: state_d = ST_ACTIVE;
                default:   state_d = ST_INACTIVE;
            endcase
        end

        soft_reset_d = (state_d == ST_INACTIVE);
        feat_tx_d    = (state_d == ST_FEATURE);
        init_fc_d    = (state_d == ST_INIT) || (state_d == ST_FC1) || (state_d == ST_FC2);
        fc1_tx_d     = (state_d == ST_FC1) ? (en_d & ~fc1f_d) : {NUM_VC{1'b0}};
        fc2_tx_d     = (state_d == ST_FC2) ? (en_d & ~fc2f_d) : {NUM_VC{1'b0}};
        case (state_d)
            ST_FC2:    status_d = DL_UP;
            ST_ACTIVE: status_d = DL_ACTIVE;
            default:   status_d = DL_DOWN;
        endcase
    end

    // State, tracking flags and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_INACTIVE;
            en_q         <= {NUM_VC{1'b0}};
            fc1f_q       <= {NUM_VC{1'b0}};
            fc2f_q       <= {NUM_VC{1'b0}};
            retry_q      <= {RETRY_W{1'b0}};
            timeout_q    <= 1'b0;
            soft_reset_q <= 1'b1;
            init_fc_q    <= 1'b0;
            feat_tx_q    <= 1'b0;
            fc1_tx_q     <= {NUM_VC{1'b0}};
            fc2_tx_q     <= {NUM_VC{1'b0}};
            status_q     <= DL_DOWN;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            fc1f_q       <= fc1f_d;
            fc2f_q       <= fc2f_d;
            retry_q      <= retry_d;
            timeout_q    <= timeout_d;
            soft_reset_q <= soft_reset_d;
            init_fc_q    <= init_fc_d;
            feat_tx_q    <= feat_tx_d;
            fc1_tx_q     <= fc1_tx_d;
            fc2_tx_q     <= fc2_tx_d;
            status_q     <= status_d;
        end
    end

    assign soft_reset_o        = soft_reset_q;
    assign init_flow_control_o = init_fc_q;
    assign feat_tx_o           = feat_tx_q;
    assign fc1_tx_o            = fc1_tx_q;
    assign fc2_tx_o            = fc2_tx_q;
    assign link_status_o       = status_q;
    assign timeout_o           = timeout_q;
    assign retry_cnt_o         = retry_q;

endmodule

// File: tb/tb_pcie_dl_init_mvc.sv
// Directed bench for pcie_dl_init_mvc: a 4-VC feature-enabled instance and a
// 1-VC plain instance, checked through an expected-value queue.
module tb_pcie_dl_init_mvc;
    import pcie_datalink_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    // Instance 0: NUM_VC=4, FEATURE_EN=1, short timeouts.
    logic            link0, init_ack0, feat_ack0;
    logic [3:0]      vc_en0, fc1_st0, fc2_st0;
    logic            sr0, ifc0, ftx0, tmo0;
    logic [3:0]      fc1tx0, fc2tx0, retry0;
    pcie_dl_status_e st0;

    // Instance 1: NUM_VC=1, FEATURE_EN=0, default timeouts.
    logic            link1, init_ack1, feat_ack1;
    logic [0:0]      vc_en1, fc1_st1, fc2_st1;
    logic            sr1, ifc1, ftx1, tmo1;
    logic [0:0]      fc1tx1, fc2tx1;
    logic [3:0]      retry1;
    pcie_dl_status_e st1;

    pcie_dl_init_mvc #(.NUM_VC(4), .FEATURE_EN(1'b1), .FEAT_TIMEOUT(16), .FC_TIMEOUT(32), .RETRY_W(4)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .phy_link_up_i(link0), .vc_en_i(vc_en0),
        .init_ack_i(init_ack0), .feat_ack_i(feat_ack0), .fc1_stored_i(fc1_st0), .fc2_stored_i(fc2_st0),
        .soft_reset_o(sr0), .init_flow_control_o(ifc0), .feat_tx_o(ftx0), .fc1_tx_o(fc1tx0),
        .fc2_tx_o(fc2tx0), .link_status_o(st0), .timeout_o(tmo0), .retry_cnt_o(retry0)
    );

    pcie_dl_init_mvc #(.NUM_VC(1), .FEATURE_EN(1'b0), .RETRY_W(4)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .phy_link_up_i(link1), .vc_en_i(vc_en1),
        .init_ack_i(init_ack1), .feat_ack_i(feat_ack1), .fc1_stored_i(fc1_st1), .fc2_stored_i(fc2_st1),
        .soft_reset_o(sr1), .init_flow_control_o(ifc1), .feat_tx_o(ftx1), .fc1_tx_o(fc1tx1),
        .fc2_tx_o(fc2tx1), .link_status_o(st1), .timeout_o(tmo1), .retry_cnt_o(retry1)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n, cnt, guard;
    logic tmo_seen;

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] v);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h", v);
        end else begin
            e = sb_q.pop_front();
            assert (v === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, v, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0;
        link0 = 1'b0; init_ack0 = 1'b0; feat_ack0 = 1'b0; vc_en0 = 4'b0000; fc1_st0 = 4'b0000; fc2_st0 = 4'b0000;
        link1 = 1'b0; init_ack1 = 1'b0; feat_ack1 = 1'b0; vc_en1 = 1'b0; fc1_st1 = 1'b0; fc2_st1 = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset values
        push_exp("rst_soft_reset", 32'd1); push_exp("rst_status", DL_DOWN); push_exp("rst_retry", 32'd0);
        push_exp("rst_feat_tx", 32'd0); push_exp("rst_init_fc", 32'd0); push_exp("rst_timeout", 32'd0);
        push_exp("rst_fc1_tx", 32'd0); push_exp("rst1_soft_reset", 32'd1);
        observe(sr0); observe(st0); observe(retry0); observe(ftx0); observe(ifc0); observe(tmo0);
        observe(fc1tx0); observe(sr1);
        rst_ni = 1'b1;
        step();
        push_exp("idle_soft_reset", 32'd1);
        observe(sr0);

        // Instance 1: plain bring-up, VC0 forced on even with vc_en=0
        link1 = 1'b1;
        push_exp("d1_soft_reset_drop", 32'd0); push_exp("d1_init_fc", 32'd1); push_exp("d1_status_init", DL_DOWN);
        step();
        observe(sr1); observe(ifc1); observe(st1);
        repeat (2) step();
        init_ack1 = 1'b1;
        push_exp("d1_fc1_tx", 32'd1); push_exp("d1_status_fc1", DL_DOWN);
        step(); init_ack1 = 1'b0;
        observe(fc1tx1); observe(st1);
        fc1_st1 = 1'b1;
        push_exp("d1_status_up", DL_UP); push_exp("d1_fc2_tx", 32'd1); push_exp("d1_fc1_tx_off", 32'd0);
        step(); fc1_st1 = 1'b0;
        observe(st1); observe(fc2tx1); observe(fc1tx1);
        fc2_st1 = 1'b1;
        push_exp("d1_status_active", DL_ACTIVE); push_exp("d1_init_fc_off", 32'd0);
        step(); fc2_st1 = 1'b0;
        observe(st1); observe(ifc1);
        repeat (5) step();
        push_exp("d1_active_hold", DL_ACTIVE);
        observe(st1);

        // Instance 0: feature phase without ack lasts FEAT_TIMEOUT cycles
        link0 = 1'b1;
        step();
        push_exp("feat_soft_reset_drop", 32'd0);
        observe(sr0);
        cnt = 0; guard = 0; tmo_seen = 1'b0;
        while (ftx0 && guard < 40) begin
            cnt++; guard++;
            if (tmo0) tmo_seen = 1'b1;
            step();
        end
        push_exp("feat_tx_cycles", 32'd16); push_exp("feat_no_timeout", 32'd0);
        push_exp("feat_to_init", 32'd1); push_exp("feat_status", DL_DOWN);
        observe(cnt); observe(tmo_seen); observe(ifc0); observe(st0);

        // FC1 with VC mask 0101; vc_en changes after sampling are ignored
        vc_en0 = 4'b0101; init_ack0 = 1'b1;
        push_exp("fc1_tx_initial", 32'h5); push_exp("fc1_status", DL_DOWN);
        step(); init_ack0 = 1'b0;
        observe(fc1tx0); observe(st0);
        vc_en0 = 4'b1111; fc1_st0 = 4'b0001;
        push_exp("fc1_tx_after_vc0", 32'h4); push_exp("fc1_still", DL_DOWN);
        step(); fc1_st0 = 4'b0000;
        observe(fc1tx0); observe(st0);
        fc1_st0 = 4'b0010;
        push_exp("fc1_disabled_vc_ignored", 32'h4); push_exp("fc1_still2", DL_DOWN);
        step(); fc1_st0 = 4'b0000;
        observe(fc1tx0); observe(st0);
        fc1_st0 = 4'b0100;
        push_exp("fc1_done_status", DL_UP); push_exp("fc1_done_tx", 32'h0); push_exp("fc2_tx_initial", 32'h5);
        step(); fc1_st0 = 4'b0000;
        observe(st0); observe(fc1tx0); observe(fc2tx0);

        // FC2 timeout with no pulses
        n = 0;
        while (!tmo0 && n < 40) begin step(); n++; end
        push_exp("fc2_timeout_cycle", 32'd32); push_exp("fc2_timeout_retry", 32'd1);
        push_exp("fc2_timeout_status", DL_DOWN); push_exp("fc2_timeout_init", 32'd1); push_exp("fc2_timeout_tx", 32'h0);
        observe(n); observe(retry0); observe(st0); observe(ifc0); observe(fc2tx0);
        step();
        push_exp("timeout_one_cycle", 32'd0);
        observe(tmo0);

        // Repeated FC1 timeouts saturate the retry counter
        for (int r = 2; r <= 16; r++) begin
            init_ack0 = 1'b1;
            push_exp("fc1_tx_all", 32'hF);
            step(); init_ack0 = 1'b0;
            observe(fc1tx0);
            n = 0;
            while (!tmo0 && n < 40) begin step(); n++; end
            push_exp("fc1_timeout_cycle", 32'd32);
            push_exp("retry_count", (r > 15) ? 32'd15 : r);
            observe(n); observe(retry0);
        end

        // Completion on the expiry cycle wins
        init_ack0 = 1'b1;
        step(); init_ack0 = 1'b0;
        repeat (31) step();
        fc1_st0 = 4'b1111;
        push_exp("race_no_timeout", 32'd0); push_exp("race_status", DL_UP); push_exp("race_retry", 32'd15);
        step(); fc1_st0 = 4'b0000;
        observe(tmo0); observe(st0); observe(retry0);

        // Link drop coincident with FC2 completion
        link0 = 1'b0; fc2_st0 = 4'b1111;
        push_exp("drop_soft_reset", 32'd1); push_exp("drop_status", DL_DOWN); push_exp("drop_retry", 32'd0);
        push_exp("drop_init_fc", 32'd0); push_exp("drop_fc2_tx", 32'h0);
        step(); fc2_st0 = 4'b0000;
        observe(sr0); observe(st0); observe(retry0); observe(ifc0); observe(fc2tx0);

        // Feature ack shortcut, then asynchronous reset mid-FC2
        link0 = 1'b1;
        push_exp("feat2_tx", 32'd1);
        step();
        observe(ftx0);
        feat_ack0 = 1'b1;
        push_exp("feat_ack_tx_off", 32'd0); push_exp("feat_ack_init", 32'd1);
        step(); feat_ack0 = 1'b0;
        observe(ftx0); observe(ifc0);
        init_ack0 = 1'b1;
        step(); init_ack0 = 1'b0;
        fc1_st0 = 4'b1111;
        push_exp("pre_reset_status", DL_UP);
        step(); fc1_st0 = 4'b0000;
        observe(st0);
        #2 rst_ni = 1'b0;
        #1;
        push_exp("async_soft_reset", 32'd1); push_exp("async_status", DL_DOWN); push_exp("async_init_fc", 32'd0);
        push_exp("async_fc2_tx", 32'h0); push_exp("async_retry", 32'd0); push_exp("async_d1_status", DL_DOWN);
        observe(sr0); observe(st0); observe(ifc0); observe(fc2tx0); observe(retry0); observe(st1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_dl_init_mvc.md
Name: pcie_dl_init_mvc

Overview:
- Data-link control/initialisation FSM for a PCIe DLL supporting up to 8 virtual channels.
- Adds an optional DL-feature exchange phase and per-VC FC1/FC2 tracking with a sticky flag per VC.
- Adds FC-init timeout with retry and a saturating retry counter.
- Sits between the PHY link-up indication and the DLLP tx/rx flow-control logic; drives DL status to the transaction layer.

Parameters:
- NUM_VC, 1, number of virtual channels (1..8); VC0 always participates.
- FEATURE_EN, 0, 1 = insert feature-exchange state before INIT.
- FEAT_TIMEOUT, 1024, cycles to wait for remote feature ack before proceeding anyway.
- FC_TIMEOUT, 4096, cycles allowed in each of FC1/FC2 before restart.
- RETRY_W, 4, width of retry counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- phy_link_up_i  in  1  physical layer reports LinkUp
- vc_en_i  in  NUM_VC  VCs enabled for init; bit 0 treated as 1 regardless of input
- init_ack_i  in  1  DLLP layer ready for FC init
- feat_ack_i  in  1  remote feature DLLP received (1-cycle pulse)
- fc1_stored_i  in  NUM_VC  per-VC InitFC1 values stored (pulses)
- fc2_stored_i  in  NUM_VC  per-VC InitFC2 values stored (pulses)
- soft_reset_o  out  1  DLL soft reset
- init_flow_control_o  out  1  FC init in progress
- feat_tx_o  out  1  request transmission of feature DLLP
- fc1_tx_o  out  NUM_VC  request InitFC1 DLLPs for VC
- fc2_tx_o  out  NUM_VC  request InitFC2 DLLPs for VC
- link_status_o  out  pcie_dl_status_e  DL_DOWN / DL_UP / DL_ACTIVE
- timeout_o  out  1  1-cycle pulse on FC timeout
- retry_cnt_o  out  RETRY_W  saturating count of FC timeouts since last INACTIVE

Behaviour:
- All outputs registered.
- Reset values: soft_reset_o=1, link_status_o=DL_DOWN, retry_cnt_o=0, all other outputs 0, state INACTIVE, flags and timer clear.
- States: INACTIVE, FEATURE, INIT, FC1, FC2, ACTIVE.
- Priority in every non-INACTIVE state: phy_link_up_i=0 wins over all other events.
  - Next edge: INACTIVE, soft_reset_o=1, flags/timer/retry cleared, link_status_o=DL_DOWN.
- INACTIVE: link_status_o=DL_DOWN. On phy_link_up_i, go to FEATURE if FEATURE_EN else INIT; soft_reset_o=0.
- FEATURE: feat_tx_o=1, timer counts.
  - Leave to INIT on feat_ack_i, or when timer reaches FEAT_TIMEOUT-1 (no retry, no timeout_o).
- INIT: init_flow_control_o=1. On init_ack_i go to FC1; timer cleared.
- FC1:
  - fc1_tx_o = enabled mask & ~fc1 flags.
  - Flag[v] set on fc1_stored_i[v] & enabled.
  - Complete when every enabled VC has (flag | same-cycle input). Next edge: FC2, link_status_o=DL_UP, timer cleared.
- FC2: same as FC1 using fc2 flags/fc2_tx_o. Complete goes to ACTIVE, link_status_o=DL_ACTIVE, init_flow_control_o=0.
- Timeout:
  - In FC1/FC2, when the timer reaches FC_TIMEOUT-1 without completion:
    - go to INIT and pulse timeout_o;
    - increment retry_cnt_o, saturating at all-ones;
    - clear fc1/fc2 flags;
    - set link_status_o=DL_DOWN.
  - Completion in the same cycle as expiry wins.
- Pulses for disabled VCs are ignored.
- vc_en_i is sampled on the INIT→FC1 transition and held until the next INIT.
- ACTIVE: only exit is link down.
- Timer width = $clog2(max(FEAT_TIMEOUT, FC_TIMEOUT)); never wraps; cleared on every state change.

Decomposition:
- pcie_datalink_pkg gets:
  - pcie_dl_init_state_e (3-bit);
  - default constants DL_FEAT_TIMEOUT and DL_FC_TIMEOUT.
- pcie_dl_status_e is reused unchanged.
- One sub-module, pcie_dl_timeout_ctr: clear/enable inputs, expiry output at programmable limit.

Test Plan:
- NUM_VC=1, FEATURE_EN=0: link up, init_ack 3 cycles later, fc1[0] then fc2[0] pulses → status DL_DOWN→DL_UP→DL_ACTIVE, each one edge after its pulse; soft_reset_o drops one edge after link up.
- NUM_VC=4, vc_en=4'b0101: fc1 on VC0 only → stays FC1 with fc1_tx_o=4'b0100. fc1 on VC2 → FC2. Pulse on VC1 has no effect.
- FEATURE_EN=1, FEAT_TIMEOUT=16, no feat_ack → feat_tx_o high exactly 16 cycles, then INIT, timeout_o stays 0.
- FC_TIMEOUT=32, no fc1 pulses → timeout_o pulse at cycle 32 of FC1, back in INIT, retry_cnt_o=1. After 16 repeats with RETRY_W=4, retry_cnt_o=15 (saturated).
- Link drop in FC2 coincident with fc2 completion → INACTIVE, DL_DOWN, soft_reset_o=1, retry cleared.
- Assert rst_ni low mid-FC2 asynchronously → all outputs at reset values before the next clock edge.
